// File: rtl/fpir_addsub_combine_stage_if.sv
// Operand/result bus of the FPIR add/sub combine stage.
// Both in_* and out_* use valid/ready: a transfer happens on a rising clock edge when valid & ready are both 1.
interface fpir_addsub_combine_stage_if #(
  parameter int BW = 43
);
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_opa;
  logic [BW-1:0] in_opb;
  logic          in_bypass;
  logic [BW-1:0] in_bypass_value;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_value;

  modport master (
    output in_valid, in_opa, in_opb, in_bypass, in_bypass_value, out_ready,
    input  in_ready, out_valid, out_value
  );

  modport slave (
    input  in_valid, in_opa, in_opb, in_bypass, in_bypass_value, out_ready,
    output in_ready, out_valid, out_value
  );
endinterface

// File: rtl/fpir_addsub_combine_stage.sv
// Second FPIR add/sub stage: adds or subtracts aligned significand magnitudes and
// emits an un-normalized FPIR result through a two-register valid/ready pipeline.
module fpir_addsub_combine_stage #(
  parameter int BW_EXPONENT    = 10,
  parameter int BW_SIGNIFICAND = 24,
  parameter int BW_GUARD       = 3,
  parameter int BW_OVERFLOW    = 2,
  parameter int BW_FPIR_TYPE   = 3,
  parameter logic [BW_FPIR_TYPE-1:0] FPIR_TYPE_NORMAL = 3'd0,
  parameter logic [BW_FPIR_TYPE-1:0] FPIR_TYPE_PZERO  = 3'd1,
  parameter int BW_FPIR_VALUE  = BW_FPIR_TYPE + 1 + BW_EXPONENT + BW_SIGNIFICAND + BW_GUARD + BW_OVERFLOW
) (
  input logic clk,
  input logic rstp,
  input logic clear,
  fpir_addsub_combine_stage_if.slave bus
);
  localparam int W        = BW_OVERFLOW + BW_SIGNIFICAND + BW_GUARD;
  localparam int GRD_LSB  = BW_OVERFLOW;
  localparam int SIG_LSB  = GRD_LSB + BW_GUARD;
  localparam int EXP_LSB  = SIG_LSB + BW_SIGNIFICAND;
  localparam int SIGN_POS = EXP_LSB + BW_EXPONENT;
  localparam int TYPE_LSB = SIGN_POS + 1;

  logic                     s1_valid;
  logic                     s1_sign_a;
  logic                     s1_sign_b;
  logic [BW_EXPONENT-1:0]   s1_exp;
  logic [W-1:0]             s1_ma;
  logic [W-1:0]             s1_mb;
  logic                     s1_bypass;
  logic [BW_FPIR_VALUE-1:0] s1_bypass_value;
  logic                     s2_valid;
  logic [BW_FPIR_VALUE-1:0] s2_value;

  logic                     s1_advance;
  logic                     s2_advance;
  logic                     accept;
  logic [W:0]               diff;
  logic [W:0]               diff_neg;
  logic [W-1:0]             mag;
  logic                     res_sign;
  logic [BW_FPIR_VALUE-1:0] result;

  // Incoming type/ovf fields and operand B's exponent carry no information here.
  logic unused_fields;
  assign unused_fields = ^{bus.in_opa[BW_FPIR_VALUE-1:TYPE_LSB], bus.in_opa[GRD_LSB-1:0],
                           bus.in_opb[BW_FPIR_VALUE-1:TYPE_LSB], bus.in_opb[SIGN_POS-1:EXP_LSB],
                           bus.in_opb[GRD_LSB-1:0]};

  assign s2_advance   = ~s2_valid | bus.out_ready;
  assign s1_advance   = s1_valid & s2_advance;
  assign bus.in_ready = ~s1_valid | s1_advance;
  assign accept       = bus.in_valid & bus.in_ready;
  assign bus.out_valid = s2_valid;
  assign bus.out_value = s2_value;

  assign diff     = {1'b0, s1_ma} - {1'b0, s1_mb};
  assign diff_neg = -diff;

  always_comb begin
    mag      = '0;
    res_sign = s1_sign_a;
    result   = '0;
    if (s1_sign_a == s1_sign_b) begin
      mag = s1_ma + s1_mb;
    end else if (diff[W]) begin
      mag      = diff_neg[W-1:0];
      res_sign = s1_sign_b;
    end else begin
      mag = diff[W-1:0];
    end
    // Exact cancellation yields +0 with every other field cleared.
    if (mag == '0) begin
      result = {FPIR_TYPE_PZERO, {(BW_FPIR_VALUE-BW_FPIR_TYPE){1'b0}}};
    end else begin
      result = {FPIR_TYPE_NORMAL, res_sign, s1_exp,
                mag[W-BW_OVERFLOW-1 -: BW_SIGNIFICAND], mag[BW_GUARD-1:0],
                mag[W-1 -: BW_OVERFLOW]};
    end
    if (s1_bypass) result = s1_bypass_value;
  end

  always_ff @(posedge clk) begin
    if (rstp || clear) begin
      s1_valid        <= 1'b0;
      s1_sign_a       <= 1'b0;
      s1_sign_b       <= 1'b0;
      s1_exp          <= '0;
      s1_ma           <= '0;
      s1_mb           <= '0;
      s1_bypass       <= 1'b0;
      s1_bypass_value <= '0;
    end else begin
      if (bus.in_ready) s1_valid <= bus.in_valid;
      if (accept) begin
        s1_sign_a       <= bus.in_opa[SIGN_POS];
        s1_sign_b       <= bus.in_opb[SIGN_POS];
        s1_exp          <= bus.in_opa[EXP_LSB +: BW_EXPONENT];
        s1_ma           <= {{BW_OVERFLOW{1'b0}}, bus.in_opa[SIG_LSB +: BW_SIGNIFICAND],
                            bus.in_opa[GRD_LSB +: BW_GUARD]};
        s1_mb           <= {{BW_OVERFLOW{1'b0}}, bus.in_opb[SIG_LSB +: BW_SIGNIFICAND],
                            bus.in_opb[GRD_LSB +: BW_GUARD]};
        s1_bypass       <= bus.in_bypass;
        s1_bypass_value <= bus.in_bypass_value;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstp || clear) begin
      s2_valid <= 1'b0;
      s2_value <= '0;
    end else if (s2_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_value <= result;
    end
  end
endmodule
